// File: rtl/sdram_port_arb_if.sv
// Request/ack bus between the port arbiter and sdram_ctrl.
// The master side issues burst requests; the slave side answers with per-word acks.
interface sdram_port_arb_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int BL_W   = 10
);
  logic              wr_req;
  logic              rd_req;
  logic [ADDR_W-1:0] addr;
  logic [BL_W-1:0]   burst_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_req, rd_req, addr, burst_len, wr_data,
    input  wr_ack, rd_ack, rd_data
  );

  modport slave (
    input  wr_req, rd_req, addr, burst_len, wr_data,
    output wr_ack, rd_ack, rd_data
  );
endinterface

// File: rtl/sdram_port_arb.sv
// N-channel round-robin front-end for sdram_ctrl with burst-granular grants
// and a wrapping address pointer per channel.
//
// state   | meaning
// IDLE    | no grant; pick next eligible channel round-robin
// REQ     | request held to controller until the first ack
// BURST   | words transferring; leave on first ack-low cycle
// DONE    | one cycle; advance or restart the granted pointer
module sdram_port_arb #(
  parameter int NCH    = 4,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int BL_W   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic [NCH-1:0]        ch_en,
  input  logic [NCH-1:0]        ch_dir,
  input  logic [NCH*ADDR_W-1:0] ch_b_addr,
  input  logic [NCH*ADDR_W-1:0] ch_e_addr,
  input  logic [NCH*BL_W-1:0]   ch_burst_len,
  input  logic [NCH*BL_W-1:0]   ch_level,
  input  logic [NCH-1:0]        ch_addr_rst,
  input  logic [NCH*DATA_W-1:0] ch_wr_data,
  output logic [NCH-1:0]        ch_wr_pop,
  output logic [NCH-1:0]        ch_rd_push,
  output logic [DATA_W-1:0]     ch_rd_data,
  output logic [NCH-1:0]        ch_busy,
  output logic [NCH-1:0]        ch_wrap,
  sdram_port_arb_if.master      sdram
);

  localparam int GW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW1 = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [ADDR_W-1:0] b_a [NCH];
  logic [ADDR_W-1:0] e_a [NCH];
  logic [BL_W-1:0]   bl_a [NCH];
  logic [BL_W-1:0]   lv_a [NCH];
  logic [DATA_W-1:0] wd_a [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
    assign b_a[gi]  = ch_b_addr[gi*ADDR_W +: ADDR_W];
    assign e_a[gi]  = ch_e_addr[gi*ADDR_W +: ADDR_W];
    assign bl_a[gi] = ch_burst_len[gi*BL_W +: BL_W];
    assign lv_a[gi] = ch_level[gi*BL_W +: BL_W];
    assign wd_a[gi] = ch_wr_data[gi*DATA_W +: DATA_W];
  end

  logic [1:0]        state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]     last_q, last_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BL_W-1:0]   len_q, len_d;
  logic              wr_req_q, wr_req_d;
  logic              rd_req_q, rd_req_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] ptr_q [NCH];
  logic [ADDR_W-1:0] ptr_d [NCH];

  logic [NCH-1:0]    elig;
  logic              pick_vld;
  logic [GW-1:0]     pick_idx;
  int                pick_i;
  logic              ack;
  logic [AW1-1:0]    len_ext;
  logic [AW1-1:0]    nxt;
  logic [AW1-1:0]    last_word;
  logic              wrap_c;
  logic              restart_g;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++) begin
      elig[i] = init_end && ch_en[i] && (bl_a[i] != '0) && (lv_a[i] >= bl_a[i]);
    end
  end

  // Search starts one past the last grant so every eligible channel gets a turn.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_i   = 0;
    for (int k = 1; k <= NCH; k++) begin
      pick_i = int'(last_q) + k;
      if (pick_i >= NCH) pick_i = pick_i - NCH;
      if (!pick_vld && elig[pick_i]) begin
        pick_vld = 1'b1;
        pick_idx = GW'(pick_i);
      end
    end
  end

  always_comb begin
    ack       = dir_q ? sdram.wr_ack : sdram.rd_ack;
    len_ext   = {{(AW1-BL_W){1'b0}}, len_q};
    nxt       = {1'b0, addr_q} + len_ext;
    last_word = nxt + len_ext - AW1'(1);
    wrap_c    = last_word > {1'b0, e_a[gnt_q]};
    restart_g = pend_q || ch_addr_rst[gnt_q];
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    dir_d    = dir_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wr_req_d = wr_req_q;
    rd_req_d = rd_req_q;
    pend_d   = pend_q;
    for (int i = 0; i < NCH; i++) begin
      ptr_d[i] = ptr_q[i];
    end

    // Restarts on the channel being granted (or about to be) are deferred to DONE.
    for (int i = 0; i < NCH; i++) begin
      if (ch_addr_rst[i]) begin
        if (state_q != S_IDLE) begin
          if (gnt_q != GW'(i)) ptr_d[i] = b_a[i];
        end else if (!(pick_vld && pick_idx == GW'(i))) begin
          ptr_d[i] = b_a[i];
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d  = S_REQ;
          gnt_d    = pick_idx;
          last_d   = pick_idx;
          dir_d    = ch_dir[pick_idx];
          addr_d   = ptr_q[pick_idx];
          len_d    = bl_a[pick_idx];
          wr_req_d = ch_dir[pick_idx];
          rd_req_d = !ch_dir[pick_idx];
          pend_d   = ch_addr_rst[pick_idx];
        end
      end
      S_REQ: begin
        pend_d = pend_q || ch_addr_rst[gnt_q];
        if (ack) begin
          state_d  = S_BURST;
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
        end
      end
      S_BURST: begin
        pend_d = pend_q || ch_addr_rst[gnt_q];
        if (!ack) state_d = S_DONE;
      end
      default: begin
        if (restart_g || wrap_c) ptr_d[gnt_q] = b_a[gnt_q];
        else                     ptr_d[gnt_q] = nxt[ADDR_W-1:0];
        pend_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      last_q   <= GW'(NCH-1);
      dir_q    <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      pend_q   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        ptr_q[i] <= b_a[i];
      end
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      pend_q   <= pend_d;
      for (int i = 0; i < NCH; i++) begin
        ptr_q[i] <= ptr_d[i];
      end
    end
  end

  always_comb begin
    ch_busy    = '0;
    ch_wrap    = '0;
    ch_wr_pop  = '0;
    ch_rd_push = '0;
    if (state_q != S_IDLE) ch_busy[gnt_q] = 1'b1;
    if (state_q == S_DONE && !restart_g && wrap_c) ch_wrap[gnt_q] = 1'b1;
    if (state_q == S_REQ || state_q == S_BURST) begin
      if (dir_q) ch_wr_pop[gnt_q]  = sdram.wr_ack;
      else       ch_rd_push[gnt_q] = sdram.rd_ack;
    end
  end

  assign ch_rd_data      = sdram.rd_data;
  assign sdram.wr_data   = wd_a[gnt_q];
  assign sdram.wr_req    = wr_req_q;
  assign sdram.rd_req    = rd_req_q;
  assign sdram.addr      = addr_q;
  assign sdram.burst_len = len_q;

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: a controller model answers requests while a
// scoreboard of predicted grants (channel, address, length, wrap) is checked.
module tb_sdram_port_arb;

  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int BW  = 10;

  logic              clk;
  logic              rst;
  logic              init_end;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    ch_dir;
  logic [NCH*AW-1:0] ch_b_addr;
  logic [NCH*AW-1:0] ch_e_addr;
  logic [NCH*BW-1:0] ch_burst_len;
  logic [NCH*BW-1:0] ch_level;
  logic [NCH-1:0]    ch_addr_rst;
  logic [NCH*DW-1:0] ch_wr_data;
  logic [NCH-1:0]    ch_wr_pop;
  logic [NCH-1:0]    ch_rd_push;
  logic [DW-1:0]     ch_rd_data;
  logic [NCH-1:0]    ch_busy;
  logic [NCH-1:0]    ch_wrap;

  sdram_port_arb_if #(.ADDR_W(AW), .DATA_W(DW), .BL_W(BW)) sdram ();

  sdram_port_arb #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .BL_W(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .init_end     (init_end),
    .ch_en        (ch_en),
    .ch_dir       (ch_dir),
    .ch_b_addr    (ch_b_addr),
    .ch_e_addr    (ch_e_addr),
    .ch_burst_len (ch_burst_len),
    .ch_level     (ch_level),
    .ch_addr_rst  (ch_addr_rst),
    .ch_wr_data   (ch_wr_data),
    .ch_wr_pop    (ch_wr_pop),
    .ch_rd_push   (ch_rd_push),
    .ch_rd_data   (ch_rd_data),
    .ch_busy      (ch_busy),
    .ch_wrap      (ch_wrap),
    .sdram        (sdram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          dir;
    int            ch;
    logic [AW-1:0] addr;
    logic [BW-1:0] len;
    logic          wrap;
  } exp_t;

  exp_t exp_q[$];

  logic [AW-1:0] b_m   [NCH];
  logic [AW-1:0] e_m   [NCH];
  logic [BW-1:0] len_m [NCH];
  logic          dir_m [NCH];
  logic [DW-1:0] wd_m  [NCH];
  logic [AW-1:0] ptr_m [NCH];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference pointer model: next burst start, wrap when the following burst would overrun.
  task automatic predict(input int ch, input bit restart);
    exp_t          e;
    logic [AW:0]   nx;
    e.ch   = ch;
    e.dir  = dir_m[ch];
    e.addr = ptr_m[ch];
    e.len  = len_m[ch];
    e.wrap = 1'b0;
    nx = {1'b0, ptr_m[ch]} + {{(AW+1-BW){1'b0}}, len_m[ch]};
    if (restart) begin
      ptr_m[ch] = b_m[ch];
    end else if (nx + {{(AW+1-BW){1'b0}}, len_m[ch]} - 1 > {1'b0, e_m[ch]}) begin
      ptr_m[ch] = b_m[ch];
      e.wrap    = 1'b1;
    end else begin
      ptr_m[ch] = nx[AW-1:0];
    end
    exp_q.push_back(e);
  endtask

  task automatic reset_model();
    for (int i = 0; i < NCH; i++) ptr_m[i] = b_m[i];
  endtask

  task automatic idle_check(input int ncyc, input string tag);
    int cnt;
    cnt = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (sdram.wr_req || sdram.rd_req || ch_busy != '0) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  // Controller model: wait for a request, ack len words, then check DONE.
  task automatic serve(input int rst_at, input int en_at, input logic [NCH-1:0] en_val);
    exp_t          e;
    int            w;
    int            good;
    logic [DW-1:0] pat;
    w = 0;
    @(negedge clk);
    while (!(sdram.wr_req || sdram.rd_req) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    if (w >= 300) begin
      chk("req_timeout", 0, 1);
      return;
    end
    chk("wr_req", sdram.wr_req, e.dir);
    chk("rd_req", sdram.rd_req, !e.dir);
    chk("addr", sdram.addr, e.addr);
    chk("burst_len", sdram.burst_len, e.len);
    chk("busy_req", ch_busy, 64'(1) << e.ch);
    good = 0;
    for (int k = 0; k < int'(e.len); k++) begin
      ch_addr_rst = '0;
      if (k == rst_at) ch_addr_rst[e.ch] = 1'b1;
      if (k == en_at) ch_en = en_val;
      pat = 16'h5A00 ^ DW'(k * 37);
      sdram.rd_data = pat;
      if (e.dir) sdram.wr_ack = 1'b1;
      else       sdram.rd_ack = 1'b1;
      #1;
      if (e.dir) begin
        if (ch_wr_pop == NCH'(1 << e.ch) && ch_rd_push == '0) good++;
        if (k == 0) chk("wr_data", sdram.wr_data, wd_m[e.ch]);
      end else begin
        if (ch_rd_push == NCH'(1 << e.ch) && ch_wr_pop == '0 && ch_rd_data == pat) good++;
      end
      if (k == 1) chk("req_drop", sdram.wr_req | sdram.rd_req, 0);
      @(negedge clk);
    end
    ch_addr_rst  = '0;
    sdram.wr_ack = 1'b0;
    sdram.rd_ack = 1'b0;
    #1;
    chk("strobes_after_ack", {ch_wr_pop, ch_rd_push}, 0);
    chk("words", good, e.len);
    @(negedge clk);
    chk("wrap", ch_wrap, e.wrap ? (64'(1) << e.ch) : 64'(0));
    chk("busy_done", ch_busy, 64'(1) << e.ch);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    b_m[0] = 24'h000100; e_m[0] = 24'h0001FF; len_m[0] = 10'd64; dir_m[0] = 1'b1; wd_m[0] = 16'hC0D0;
    b_m[1] = 24'h001000; e_m[1] = 24'h001FFF; len_m[1] = 10'd16; dir_m[1] = 1'b0; wd_m[1] = 16'hC1D1;
    b_m[2] = 24'h002000; e_m[2] = 24'h0020FF; len_m[2] = 10'd8;  dir_m[2] = 1'b1; wd_m[2] = 16'hC2D2;
    b_m[3] = 24'h003000; e_m[3] = 24'h0030FF; len_m[3] = 10'd4;  dir_m[3] = 1'b0; wd_m[3] = 16'hC3D3;
    for (int i = 0; i < NCH; i++) begin
      ch_b_addr[i*AW +: AW]    = b_m[i];
      ch_e_addr[i*AW +: AW]    = e_m[i];
      ch_burst_len[i*BW +: BW] = len_m[i];
      ch_dir[i]                = dir_m[i];
      ch_wr_data[i*DW +: DW]   = wd_m[i];
      ch_level[i*BW +: BW]     = len_m[i];
    end
    ch_level[1*BW +: BW] = 10'd10;
    rst           = 1'b1;
    init_end      = 1'b0;
    ch_en         = '0;
    ch_addr_rst   = '0;
    sdram.wr_ack  = 1'b0;
    sdram.rd_ack  = 1'b0;
    sdram.rd_data = '0;
    reset_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_wr_req", sdram.wr_req, 0);
    chk("rst_rd_req", sdram.rd_req, 0);
    chk("rst_addr", sdram.addr, 0);
    chk("rst_len", sdram.burst_len, 0);
    chk("rst_busy", ch_busy, 0);
    chk("rst_wrap", ch_wrap, 0);
    chk("rst_strobes", {ch_wr_pop, ch_rd_push}, 0);

    // Eligible channel held off by init_end.
    ch_en = 4'b0001;
    idle_check(12, "gated_by_init_end");
    init_end = 1'b1;

    // Single write plus four-burst window wrap and fifth burst back at the base.
    for (int i = 0; i < 5; i++) predict(0, 1'b0);
    for (int i = 0; i < 5; i++) serve(-1, -1, '0);

    // Restart mid-burst at 0x140, then a burst at 0x100 with enable dropped mid-burst.
    predict(0, 1'b1);
    serve(10, -1, '0);
    predict(0, 1'b0);
    serve(-1, 5, 4'b0000);
    idle_check(10, "disabled_no_grant");

    // Read channel: free space below the burst length blocks the request.
    ch_en = 4'b0010;
    idle_check(10, "read_level_low");
    ch_level[1*BW +: BW] = 10'd16;
    predict(1, 1'b0);
    serve(-1, 3, 4'b0000);
    idle_check(6, "read_done_idle");

    // Round-robin from a fresh reset, then a single eligible channel.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    ch_en = 4'b1111;
    predict(0, 1'b0); predict(1, 1'b0); predict(2, 1'b0); predict(3, 1'b0); predict(0, 1'b0);
    for (int i = 0; i < 4; i++) serve(-1, -1, '0);
    serve(-1, 5, 4'b0100);
    for (int i = 0; i < 3; i++) predict(2, 1'b0);
    serve(-1, -1, '0);
    serve(-1, -1, '0);
    serve(-1, 2, 4'b0000);
    idle_check(6, "rr_off");

    // Reset asserted in the middle of a burst.
    ch_en = 4'b0001;
    w = 0;
    @(negedge clk);
    while (!sdram.wr_req && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("mid_rst_req_seen", w < 300, 1);
    chk("mid_rst_addr", sdram.addr, ptr_m[0]);
    repeat (5) begin
      sdram.wr_ack = 1'b1;
      @(negedge clk);
    end
    rst          = 1'b1;
    sdram.wr_ack = 1'b0;
    ch_en        = '0;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    chk("mid_rst_busy", ch_busy, 0);
    chk("mid_rst_reqs", {sdram.wr_req, sdram.rd_req}, 0);
    chk("mid_rst_addr_out", sdram.addr, 0);
    chk("mid_rst_len_out", sdram.burst_len, 0);
    chk("mid_rst_wrap", ch_wrap, 0);
    ch_en = 4'b0001;
    predict(0, 1'b0);
    serve(-1, 5, 4'b0000);
    idle_check(4, "final_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_port_arb.md
# sdram_port_arb

Parametrised N-channel front-end for the SDRAM controller. It generalises the single write-FIFO/read-FIFO pairing into `NCH` independent channels. Each channel has its own direction, address window, burst length and restart control. Channels are served round-robin with burst-granular grants, and each channel keeps its own wrapping address pointer. The block sits between the per-channel single-clock FIFOs and `sdram_ctrl`'s request/ack interface.

## Interface
- `NCH`, 4: number of channels (2..8).
- `ADDR_W`, 24: SDRAM word address width.
- `DATA_W`, 16: data width.
- `BL_W`, 10: burst-length and FIFO-level width.
- `clk` in 1: single clock; everything is synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `init_end` in 1: SDRAM initialisation done. No grant is issued while it is low.
- `ch_en` in NCH: per-channel enable.
- `ch_dir` in NCH: 1 = write channel, 0 = read channel. Static while `ch_en` is high.
- `ch_b_addr` in NCH*ADDR_W: window begin address, channel i at `[i*ADDR_W +: ADDR_W]`.
- `ch_e_addr` in NCH*ADDR_W: window end address, inclusive.
- `ch_burst_len` in NCH*BL_W: words per burst.
- `ch_level` in NCH*BL_W: words available in the write FIFO, or free space in the read FIFO.
- `ch_addr_rst` in NCH: pulse that restarts the channel pointer at `ch_b_addr`.
- `ch_wr_data` in NCH*DATA_W: write FIFO head words.
- `ch_wr_pop` out NCH: write FIFO read strobe.
- `ch_rd_push` out NCH: read FIFO write strobe.
- `ch_rd_data` out DATA_W: read data, broadcast to all channels.
- `ch_busy` out NCH: channel currently granted.
- `ch_wrap` out NCH: one-cycle pulse when the channel pointer wraps.
- `sdram_wr_req`, `sdram_rd_req` out 1: requests to the controller.
- `sdram_addr` out ADDR_W: burst start address.
- `sdram_burst_len` out BL_W: burst length.
- `sdram_wr_data` out DATA_W: write data to the controller.
- `sdram_wr_ack`, `sdram_rd_ack` in 1: per-word acks from the controller.
- `sdram_rd_data` in DATA_W: read data from the controller.

## Operation
- **FSM states:** IDLE, REQ, BURST, DONE.
- **Eligibility.** Channel i is eligible when all of the following hold:
  - `init_end` is high and `ch_en[i]` is high;
  - `ch_burst_len[i]` is not 0;
  - `ch_level[i] >= ch_burst_len[i]`.
- **IDLE.** If any channel is eligible, grant the first eligible channel searching upward from (last grant + 1) mod NCH, then go to REQ. After reset the search starts at channel 0.
- **REQ.** Drive `sdram_wr_req` (write channel) or `sdram_rd_req` (read channel). Hold `sdram_addr` = pointer[g] and `sdram_burst_len` = `ch_burst_len[g]`, latched at grant. Go to BURST on the first cycle the matching ack is high; the request drops in that same cycle.
- **BURST.** Count ack cycles. Leave for DONE on the first cycle the ack is low after having been high. The count is informational only.
- **DONE (one cycle).** Advance the granted pointer, then return to IDLE.
  - `next` = ptr + len, computed at ADDR_W+1 bits.
  - If `next + len - 1 > ch_e_addr`, set ptr to `ch_b_addr` and pulse `ch_wrap[g]`.
  - Otherwise set ptr to `next`.
- **Data path (combinational):**
  - `sdram_wr_data` = `ch_wr_data[g]`.
  - `ch_wr_pop[g]` = `sdram_wr_ack` while in REQ or BURST with a write grant.
  - `ch_rd_push[g]` = `sdram_rd_ack` while in REQ or BURST with a read grant.
  - `ch_rd_data` = `sdram_rd_data`.
  - All other strobe bits are 0.
- **Address restart.**
  - `ch_addr_rst[i]` on a non-granted channel sets pointer[i] to `ch_b_addr[i]` on the next edge.
  - On the granted channel the restart is held pending and applied in DONE, overriding the advance, with no `ch_wrap` pulse.
- **Disable mid-burst.** Deasserting `ch_en` of the granted channel does not abort the burst. It only removes eligibility from then on.
- **Reset values.**
  - All pointers = `ch_b_addr` sampled at reset; FSM = IDLE.
  - All request and strobe outputs = 0; `ch_busy` = 0; `ch_wrap` = 0.
  - `sdram_addr` = 0; `sdram_burst_len` = 0.
  - `rst` during any state returns to IDLE on the next edge with no pointer advance.

## Timing
- Eligibility sampled at edge t puts the request high from t+1.
- The request holds until the ack edge, then drops the same cycle.
- Burst end is the first ack-low cycle; DONE follows one cycle later; IDLE can re-grant the cycle after that. Minimum gap between bursts: 2 idle cycles.
- `ch_busy[g]` is high from REQ through DONE inclusive.
- `ch_wrap` is aligned with DONE.
- Requests to the controller are registered; data-path strobes are combinational, with zero latency from ack.

## Test plan
- **Single write.**
  - Setup: ch0 write, b=0x000100, e=0x0001FF, len=64, level=64.
  - Required: `sdram_wr_req` with addr 0x000100 and len 64; 64 `ch_wr_pop[0]` pulses; next addr 0x000140.
- **Window wrap.**
  - Setup: same window; four bursts.
  - Required: addresses 0x100, 0x140, 0x180, 0x1C0; `ch_wrap[0]` pulses after the 4th burst; 5th burst addr 0x100.
- **Round-robin.**
  - Setup: ch0..ch3 all eligible and remaining eligible.
  - Required: grant order 0,1,2,3,0. Then with only ch2 eligible, consecutive grants all go to ch2.
- **Read path.**
  - Setup: ch1 read, level (free space)=10, len=16.
  - Required: no request. After raising level to 16: `sdram_rd_req`, and 16 `ch_rd_push[1]` pulses matching `sdram_rd_data`.
- **Restart during burst.**
  - Setup: `ch_addr_rst[0]` pulsed mid-burst at ptr 0x140.
  - Required: next ch0 addr 0x100; no `ch_wrap`.
- **Gating and reset.**
  - Setup: `init_end`=0 with eligible channels; then `rst` asserted in BURST.
  - Required: no request while `init_end` is low. After the reset: FSM in IDLE, outputs 0, pointers = b_addr.
